// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART transmit path.
//
// Contents:
//   DEFAULT_DATA_BITS / DEFAULT_STOP_BITS : default frame shape (8N1).
//   LINE_IDLE                             : level of the serial line when idle.
//   uart_state_e                          : transmitter state encoding.
//
// The PARITY state value is always defined so the encoding is identical
// whether or not UART_TX_PARITY_EN is set in a given build.
package uart_pkg;

  localparam int   DEFAULT_DATA_BITS = 8;
  localparam int   DEFAULT_STOP_BITS = 1;
  localparam logic LINE_IDLE         = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } uart_state_e;

endpackage

// File: rtl/uart_tx.sv
// uart_tx -- UART transmitter, LSB first, one bit per i_tick interval.
//
// Parameters:
//   DATA_BITS  data bits per frame (5..8)
//   STOP_BITS  stop bits per frame (1..2)
//
// Ports:
//   i_clk    system clock, all logic on its rising edge
//   i_reset  asynchronous active-high reset
//   i_tick   one-cycle baud enable from the tx clock divider
//   i_data   byte to send, captured when i_valid && o_ready
//   i_valid  upstream has a byte to send
//   o_ready  high only while idle; a byte offered then is accepted
//   o_tx     registered serial line, idle high
//   o_done   one-cycle pulse in the first idle cycle after the last stop bit
//
// Build option:
//   UART_TX_PARITY_EN  when defined, an even-parity bit (XOR of the data
//                      bits) is sent between the last data bit and the stop
//                      bits. When undefined the parity state and logic are
//                      absent and the frame is 1 + DATA_BITS + STOP_BITS bits.
//
// Every bit boundary is a tick edge, so o_tx only changes in the cycle after
// an i_tick. After acceptance the block waits in WAIT for the next tick so the
// start bit is a full tick interval long; a tick on the acceptance edge itself
// is seen while still in IDLE and is therefore not used.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter int STOP_BITS = DEFAULT_STOP_BITS
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_tick,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_tx,
  output logic                 o_done
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
  localparam logic [1:0]       LAST_STOP = 2'(STOP_BITS - 1);

  uart_state_e          r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [1:0]           r_stop_cnt;
  logic                 r_tx;
  logic                 r_done;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity;
`endif

  logic w_idle;
  logic w_accept;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = w_idle && i_valid;

  assign o_ready = w_idle;
  assign o_tx    = r_tx;
  assign o_done  = r_done;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= '0;
      r_tx       <= LINE_IDLE;
      r_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_tx <= LINE_IDLE;
          // i_tick is deliberately ignored here, including on the
          // acceptance edge.
          if (w_accept) begin
            r_shift    <= i_data;
            r_bit_cnt  <= '0;
            r_stop_cnt <= '0;
`ifdef UART_TX_PARITY_EN
            // Parity is taken from the captured byte because the shift
            // register is consumed while the data bits go out.
            r_parity   <= ^i_data;
`endif
            r_state    <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (i_tick) begin
            r_tx    <= 1'b0;
            r_state <= ST_START;
          end
        end

        ST_START: begin
          if (i_tick) begin
            r_tx      <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= '0;
            r_state   <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (i_tick) begin
            // r_bit_cnt names the bit currently on the line; when the
            // last one has elapsed the frame moves on.
            if (r_bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              r_tx    <= r_parity;
              r_state <= ST_PARITY;
`else
              r_tx    <= LINE_IDLE;
              r_state <= ST_STOP;
`endif
            end else begin
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (i_tick) begin
            r_tx    <= LINE_IDLE;
            r_state <= ST_STOP;
          end
        end
`endif

        ST_STOP: begin
          r_tx <= LINE_IDLE;
          if (i_tick) begin
            if (r_stop_cnt == LAST_STOP) begin
              r_stop_cnt <= '0;
              r_done     <= 1'b1;
              r_state    <= ST_IDLE;
            end else begin
              r_stop_cnt <= r_stop_cnt + 1'b1;
            end
          end
        end

        default: begin
          r_tx    <= LINE_IDLE;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- self-checking bench for uart_tx (default DATA_BITS/STOP_BITS).
// Tick period is 4 clocks. A queue-based line model is advanced every clock
// and compared with o_tx / o_done / o_ready; a table of bytes with expected
// frames is sent and decoded from the line; hand-written sequences cover
// back-to-back frames, ignored input while busy, reset mid-frame and a tick
// coinciding with acceptance. Honours UART_TX_PARITY_EN like the design.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int DB = DEFAULT_DATA_BITS;
  localparam int SB = DEFAULT_STOP_BITS;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NBITS = 1 + DB + PB + SB;

  logic          clk   = 1'b0;
  logic          rst   = 1'b0;
  logic          tick  = 1'b0;
  logic          valid = 1'b0;
  logic [DB-1:0] data  = '0;
  logic          ready;
  logic          tx;
  logic          done;

  always #5 clk = ~clk;

  uart_tx #(.DATA_BITS(DB), .STOP_BITS(SB)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_tick  (tick),
    .i_data  (data),
    .i_valid (valid),
    .o_ready (ready),
    .o_tx    (tx),
    .o_done  (done)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: busy flag plus the queue of frame bits still to appear.
  bit m_busy = 1'b0;
  bit m_line = 1'b1;
  bit m_done = 1'b0;
  bit q[$];

  typedef struct {
    logic [7:0]  data;
    logic [15:0] exp;   // bit 0 = start bit, bit 1 = data LSB, ...
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_load(input logic [DB-1:0] d);
    q.delete();
    q.push_back(1'b0);
    for (int i = 0; i < DB; i++) q.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    q.push_back(^d);
`endif
    for (int i = 0; i < SB; i++) q.push_back(1'b1);
  endtask

  // One clock: drive tick, advance the model across the edge, compare at negedge.
  task automatic step();
    tick = ((cyc % 4) == 3);
    @(posedge clk);
    cyc++;
    m_done = 1'b0;
    if (!m_busy) begin
      if (valid) begin
        m_busy = 1'b1;
        model_load(data);
      end
    end else if (tick) begin
      if (q.size() > 0) m_line = q.pop_front();
      else begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end
    @(negedge clk);
    check("cyc_tx", 32'(tx), 32'(m_line));
    check("cyc_done", 32'(done), 32'(m_done));
    check("cyc_ready", 32'(ready), 32'(!m_busy));
  endtask

  // Called at a negedge: asserts reset between edges and checks its immediate effect.
  task automatic async_reset();
    #2;
    rst   = 1'b1;
    tick  = 1'b0;
    valid = 1'b0;
    #1;
    m_busy = 1'b0;
    m_line = 1'b1;
    m_done = 1'b0;
    q.delete();
    check("rst_tx_immediate", 32'(tx), 32'd1);
    check("rst_done_low", 32'(done), 32'd0);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready_after_release", 32'(ready), 32'd1);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 100 && !ready; i++) step();
  endtask

  task automatic wait_done(output bit found);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (done) found = 1'b1;
    end
  endtask

  // Send one byte and decode the line: bit b of the frame is sampled one clock
  // into its 4-clock interval; every interval must be constant.
  task automatic send_capture(input logic [DB-1:0] d, output logic [15:0] got,
                              output int ndone, output bit held);
    bit log_tx[64];
    int first;
    got   = '0;
    ndone = 0;
    held  = 1'b1;
    first = -1;
    valid = 1'b1;
    data  = d;
    wait_ready();
    step();
    valid = 1'b0;
    for (int i = 0; i < 64; i++) begin
      step();
      log_tx[i] = tx;
      if (done) ndone++;
    end
    for (int i = 0; i < 64; i++)
      if (first < 0 && log_tx[i] == 1'b0) first = i;
    if (first >= 0 && first + 4 * NBITS <= 64) begin
      for (int b = 0; b < NBITS; b++) begin
        got[b] = log_tx[first + 4 * b + 1];
        for (int j = 1; j < 4; j++)
          if (log_tx[first + 4 * b + j] != log_tx[first + 4 * b]) held = 1'b0;
      end
    end else begin
      held = 1'b0;
    end
  endtask

  initial begin
    logic [15:0] got;
    int          nd;
    bit          held;
    bit          found;
    int          n;
    int          cnt;

`ifdef UART_TX_PARITY_EN
    vecs[0] = '{8'h55, 16'({1'b1, 1'b0, 8'h55, 1'b0})};
    vecs[1] = '{8'h07, 16'({1'b1, 1'b1, 8'h07, 1'b0})};
    vecs[2] = '{8'h00, 16'({1'b1, 1'b0, 8'h00, 1'b0})};
    vecs[3] = '{8'hFF, 16'({1'b1, 1'b0, 8'hFF, 1'b0})};
    vecs[4] = '{8'h81, 16'({1'b1, 1'b0, 8'h81, 1'b0})};
    vecs[5] = '{8'h01, 16'({1'b1, 1'b1, 8'h01, 1'b0})};
`else
    vecs[0] = '{8'h55, 16'({1'b1, 8'h55, 1'b0})};
    vecs[1] = '{8'h07, 16'({1'b1, 8'h07, 1'b0})};
    vecs[2] = '{8'h00, 16'({1'b1, 8'h00, 1'b0})};
    vecs[3] = '{8'hFF, 16'({1'b1, 8'hFF, 1'b0})};
    vecs[4] = '{8'h81, 16'({1'b1, 8'h81, 1'b0})};
    vecs[5] = '{8'h01, 16'({1'b1, 8'h01, 1'b0})};
`endif

    // Power-on reset: asserted before the first clock edge.
    #1 rst = 1'b1;
    #1;
    check("por_tx", 32'(tx), 32'd1);
    check("por_done", 32'(done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("por_ready", 32'(ready), 32'd1);

    // Table of single frames.
    for (int v = 0; v < 6; v++) begin
      send_capture(vecs[v].data, got, nd, held);
      check($sformatf("frame_%02h_bits", vecs[v].data), 32'(got), 32'(vecs[v].exp));
      check($sformatf("frame_%02h_done_pulses", vecs[v].data), nd, 1);
      check($sformatf("frame_%02h_bit_width", vecs[v].data), 32'(held), 32'd1);
      check($sformatf("frame_%02h_ready_after", vecs[v].data), 32'(ready), 32'd1);
      $display("frame %02h sent, decoded %04h", vecs[v].data, got);
    end

    // Back-to-back: valid held, second byte taken in the o_done cycle.
    valid = 1'b1;
    data  = 8'hA3;
    wait_ready();
    step();
    data = 8'h3C;
    wait_done(found);
    check("b2b_first_done", 32'(found), 32'd1);
    check("b2b_ready_with_done", 32'(ready), 32'd1);
    step();
    valid = 1'b0;
    check("b2b_second_accepted", 32'(ready), 32'd0);
    wait_done(found);
    check("b2b_second_done", 32'(found), 32'd1);
    $display("back-to-back A3/3C sent");

    // Input while busy is ignored.
    valid = 1'b1;
    data  = 8'h00;
    wait_ready();
    step();
    valid = 1'b0;
    repeat (14) step();
    valid = 1'b1;
    data  = 8'hFF;
    step();
    valid = 1'b0;
    data  = 8'h00;
    wait_done(found);
    check("busy_frame_done", 32'(found), 32'd1);
    cnt = 0;
    repeat (12) begin
      step();
      if (!tx) cnt++;
    end
    check("busy_input_not_sent", cnt, 0);
    $display("busy pulse FF during 00 frame");

    // Reset during data bit 4, then a clean 0x81 frame.
    valid = 1'b1;
    data  = 8'h00;
    wait_ready();
    step();
    valid = 1'b0;
    for (int i = 0; i < 100 && q.size() != NBITS - 6; i++) step();
    step();
    check("bit4_line_low", 32'(tx), 32'd0);
    async_reset();
    found = 1'b0;
    repeat (12) begin
      step();
      if (done) found = 1'b1;
    end
    check("reset_no_done", 32'(found), 32'd0);
    send_capture(8'h81, got, nd, held);
    check("after_reset_81_bits", 32'(got), 32'(vecs[4].exp));
    check("after_reset_81_done", nd, 1);
    $display("reset in bit 4, then frame 81 decoded %04h", got);

    // Tick on the acceptance edge is not used.
    wait_ready();
    for (int i = 0; i < 4 && (cyc % 4) != 3; i++) step();
    valid = 1'b1;
    data  = 8'h5B;
    step();
    valid = 1'b0;
    n = 0;
    for (int i = 0; i < 12 && tx; i++) begin
      step();
      n++;
    end
    check("coincident_tick_start_delay", n, 4);
    cnt = 1;
    for (int i = 0; i < 8 && !tx; i++) begin
      step();
      if (!tx) cnt++;
    end
    check("coincident_start_len", cnt, 4);
    wait_done(found);
    check("coincident_done", 32'(found), 32'd1);
    $display("coincident tick: start after %0d clocks, %0d clocks long", n, cnt);

    // Random traffic against the model, with occasional reset.
    for (int i = 0; i < 600; i++) begin
      valid = ($urandom_range(2) == 0);
      data  = DB'($urandom);
      if ($urandom_range(199) == 0) async_reset();
      else step();
    end
    valid = 1'b0;
    wait_ready();
    repeat (4) step();
    $display("random phase complete");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, number of data bits per frame (legal 5..8).
REQ-002 SHALL have parameter STOP_BITS, default 1, number of stop bits per frame (legal 1..2).
REQ-003 SHALL have port i_clk  input  1  single system clock; all logic on posedge.
REQ-004 SHALL have port i_reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_tick  input  1  one-cycle baud enable from the tx clock divider; one bit period = interval between ticks.
REQ-006 SHALL have port i_data  input  DATA_BITS  byte to send, sampled on acceptance.
REQ-007 SHALL have port i_valid  input  1  upstream has a byte to send.
REQ-008 SHALL have port o_ready  output  1  block can accept a byte.
REQ-009 SHALL have port o_tx  output  1  serial line, idle high, registered.
REQ-010 SHALL have port o_done  output  1  one-cycle pulse at end of last stop bit.

Function
REQ-011 SHALL accept a byte on a rising i_clk edge where i_valid and o_ready are both 1; i_data latched into the shift register at that edge.
REQ-012 SHALL drive o_ready high only in IDLE; o_ready low from the cycle after acceptance until return to IDLE.
REQ-013 SHALL ignore i_valid and i_data while o_ready is low; no queuing.
REQ-014 SHALL implement states IDLE, WAIT, START, DATA, PARITY, STOP.
REQ-015 IDLE: o_tx=1; on acceptance -> WAIT.
REQ-016 WAIT: o_tx=1; on i_tick -> START with o_tx=0 from the next cycle; a tick coinciding with the acceptance edge is not consumed.
REQ-017 START: on i_tick -> DATA, o_tx = bit 0 (LSB first).
REQ-018 DATA: on each i_tick shift next bit out; bit counter 0..DATA_BITS-1; after bit DATA_BITS-1 elapses -> PARITY (if enabled) else STOP with o_tx=1.
REQ-019 STOP: o_tx=1; on each i_tick increment stop counter; after STOP_BITS ticks -> IDLE, o_done=1 for exactly that one cycle.
REQ-020 Every bit (start, data, parity, stop) SHALL last exactly one tick interval; o_tx changes only in the cycle after an i_tick.
REQ-021 SHALL allow a new acceptance in the first IDLE cycle (same cycle o_done is high), giving back-to-back frames with no extra idle bit.
REQ-022 i_tick outside WAIT..STOP SHALL have no effect.
REQ-023 Counters SHALL be sized ceil(log2(DATA_BITS+1)) and 2 bits respectively; no wrap-around within a frame.

Reset
REQ-024 On i_reset=1, immediately (asynchronous): state=IDLE, o_tx=1, o_ready=1 after reset release, o_done=0, counters and shift register=0.
REQ-025 Reset mid-frame SHALL abort the frame, line returns high at once, latched data discarded, no o_done.

Configuration
REQ-026 Macro UART_TX_PARITY_EN defined: PARITY state present; after data, one bit of even parity (XOR of latched data bits) sent for one tick interval, then STOP.
REQ-027 Macro UART_TX_PARITY_EN undefined: PARITY state and parity logic absent; DATA -> STOP directly; frame = 1+DATA_BITS+STOP_BITS bits.

Structure
REQ-028 Shared package uart_pkg SHALL hold the state enum (IDLE..STOP), default DATA_BITS/STOP_BITS constants and the idle-line level constant.
REQ-029 No sub-module; uart_tx consumes i_tick from the existing tx clock divider instantiated beside it at the UART top level.

Verification (tick every 4 clocks in sim)
REQ-030 Reset, send 0x55, parity off -> o_tx sequence 0,1,0,1,0,1,0,1,0,1 then 1, each held 4 cycles; o_done single pulse; o_ready back high.
REQ-031 Parity on, send 0x07 -> data 1,1,1,0,0,0,0,0, parity bit 1, stop 1.
REQ-032 i_valid held high with 0xA3 then 0x3C -> two frames back-to-back, no idle gap, second byte accepted in o_done cycle.
REQ-033 Pulse i_valid with 0xFF during DATA of frame 0x00 -> ignored, only 0x00 transmitted.
REQ-034 Assert i_reset in DATA bit 4 -> o_tx=1 same cycle, no o_done, next accepted byte 0x81 sent correctly.
REQ-035 Tick coincident with acceptance edge -> start bit begins after the following tick, full 4-cycle duration.
